inv_mix_columns_iter: RTL and testbench

- Iterative AES InvMixColumns engine for the decryption datapath. Sits between the AddRoundKey stage and the InvShiftRows/InvSubBytes stage of each inverse round.
- Processes one 32-bit column per clock through shared GF(2^8) multiply-by-{09,0b,0d,0e} logic.
- Uses valid/ready handshakes on both sides, so it can stall against downstream back-pressure.

---
 rtl/inv_mix_columns_iter.sv | 156 +++++++++++++++
 tb/tb_inv_mix_columns_iter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_columns_iter.sv
// inv_mix_columns_iter: AES InvMixColumns engine with valid/ready handshakes.
// The default build runs one column per clock through a single shared column
// unit. Defining INV_MIX_COL_PARALLEL_EN instantiates four column units
// and finishes the state in one BUSY cycle. Results are identical in both modes.

// One column of InvMixColumns, built from chained xtime plus XOR.
module inv_mix_col #(
  parameter int COL_LEN = 32
) (
  input  logic [COL_LEN-1:0] col,
  output logic [COL_LEN-1:0] res
);
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [3:0][7:0] a, x2, x4, x8, m9, mb, md, me, b;

  // Row 0 sits in the top byte, so a[0] is col[31:24]. Each output byte
  // combines all four multiples, rotated by its row.
  always_comb begin
    a   = '0;
    x2  = '0;
    x4  = '0;
    x8  = '0;
    m9  = '0;
    mb  = '0;
    md  = '0;
    me  = '0;
    b   = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[COL_LEN-1-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    for (int i = 0; i < 4; i++)
      b[i] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    res = {b[0], b[1], b[2], b[3]};
  end
endmodule

module inv_mix_columns_iter #(
  parameter int DATA_LEN = 128,
  parameter int COL_LEN  = DATA_LEN / 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] data_out
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic [1:0]          col_cnt;
  logic [DATA_LEN-1:0] work;
  logic [DATA_LEN-1:0] work_nxt;

`ifdef INV_MIX_COL_PARALLEL_EN
  // Four column units transform the whole working state in one cycle.
  for (genvar c = 0; c < 4; c++) begin : g_col
    inv_mix_col #(.COL_LEN(COL_LEN)) u_col (
      .col (work[DATA_LEN-1-COL_LEN*c -: COL_LEN]),
      .res (work_nxt[DATA_LEN-1-COL_LEN*c -: COL_LEN])
    );
  end
`else
  logic [COL_LEN-1:0] col_sel, col_res;

  inv_mix_col #(.COL_LEN(COL_LEN)) u_col (
    .col (col_sel),
    .res (col_res)
  );

  // Route column col_cnt through the shared unit and splice the result back.
  always_comb begin
    work_nxt = work;
    col_sel  = '0;
    case (col_cnt)
      2'd0: begin
        col_sel = work[DATA_LEN-1 -: COL_LEN];
        work_nxt[DATA_LEN-1 -: COL_LEN] = col_res;
      end
      2'd1: begin
        col_sel = work[DATA_LEN-1-COL_LEN -: COL_LEN];
        work_nxt[DATA_LEN-1-COL_LEN -: COL_LEN] = col_res;
      end
      2'd2: begin
        col_sel = work[DATA_LEN-1-2*COL_LEN -: COL_LEN];
        work_nxt[DATA_LEN-1-2*COL_LEN -: COL_LEN] = col_res;
      end
      default: begin
        col_sel = work[COL_LEN-1:0];
        work_nxt[COL_LEN-1:0] = col_res;
      end
    endcase
  end
`endif

  // Control FSM with registered handshake outputs; data_out only moves on BUSY->DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      col_cnt   <= 2'd0;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work     <= data_in;
          col_cnt  <= 2'd0;
          in_ready <= 1'b0;
          state    <= BUSY;
        end
        BUSY: begin
          work <= work_nxt;
`ifdef INV_MIX_COL_PARALLEL_EN
          // col_cnt stays at 0: every column finishes in this single cycle.
          col_cnt   <= 2'd0;
          data_out  <= work_nxt;
          out_valid <= 1'b1;
          state     <= DONE;
`else
          if (col_cnt == 2'd3) begin
            col_cnt   <= 2'd0;
            data_out  <= work_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            col_cnt <= col_cnt + 2'd1;
          end
`endif
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Bench for inv_mix_columns_iter: directed reference vectors, back-pressure,
// mid-operation reset and a random stream, all scored against a GF(2^8)
// matrix model of (Inv)MixColumns.
module tb_inv_mix_columns_iter;
`ifdef INV_MIX_COL_PARALLEL_EN
  localparam int LAT = 1;
  localparam int IVL = 3;
  localparam int ABORT_STEPS = 0;
`else
  localparam int LAT = 4;
  localparam int IVL = 6;
  localparam int ABORT_STEPS = 2;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] data_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] data_out;

  int total = 0;
  int bad = 0;

  inv_mix_columns_iter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  // Shift-and-add GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product per column; inv selects {0e,0b,0d,09} vs {02,03,01,01}.
  function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
    logic [7:0] coef [4];
    logic [7:0] by [16];
    logic [7:0] acc;
    logic [127:0] r = '0;
    if (inv) begin coef[0]=8'h0e; coef[1]=8'h0b; coef[2]=8'h0d; coef[3]=8'h09; end
    else     begin coef[0]=8'h02; coef[1]=8'h03; coef[2]=8'h01; coef[3]=8'h01; end
    for (int n = 0; n < 16; n++) by[n] = s[127-8*n -: 8];
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gmul(coef[k], by[4*c + (i+k)%4]);
        r[127-32*c-8*i -: 8] = acc;
      end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; data_in = '1; out_ready = 1'b1;
    repeat (3) step();
    reset = 1'b1; in_valid = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (data_out !== 128'h0) begin bad++; $display("FAIL reset_data_out got=%h want=0", data_out); end
    repeat (6) step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL reset_no_capture out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reference();
    logic [127:0] din = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    logic [127:0] exp = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    int early = 0;
    out_ready = 1'b1; data_in = din; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k < LAT && out_valid !== 1'b0) early++;
    end
    total++; if (early != 0) begin bad++; $display("FAIL ref_early_valid got=%0d cycles want=0", early); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ref_latency out_valid=%b want=1", out_valid); end
    total++; if (data_out !== exp) begin bad++; $display("FAIL ref_data got=%h want=%h", data_out, exp); end
    total++; if (data_out !== mix(din, 1'b1)) begin bad++; $display("FAIL ref_model got=%h want=%h", data_out, mix(din, 1'b1)); end
    step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL ref_drop out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    total++; if (data_out !== exp) begin bad++; $display("FAIL ref_hold got=%h want=%h", data_out, exp); end
  endtask

  task automatic test_second();
    logic [127:0] din = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    logic [127:0] exp = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    int n = 0;
    out_ready = 1'b1; data_in = din; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL second_timeout out_valid=%b want=1", out_valid); end
    total++; if (data_out !== exp) begin bad++; $display("FAIL second_data got=%h want=%h", data_out, exp); end
    step();
  endtask

  task automatic test_backpressure();
    logic [127:0] din = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] exp = mix(din, 1'b1);
    int n = 0;
    int viol = 0;
    out_ready = 1'b0; data_in = din; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout out_valid=%b want=1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      data_in  = ~din;
      step();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== exp) viol++;
    end
    in_valid = 1'b0;
    total++; if (viol != 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles want=0 (data=%h want=%h)", viol, data_out, exp); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL bp_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    viol = 0;
    repeat (8) begin step(); if (out_valid !== 1'b0) viol++; end
    total++; if (viol != 0) begin bad++; $display("FAIL bp_no_accept got=%0d valid cycles want=0", viol); end
  endtask

  task automatic test_abort();
    logic [127:0] din = {$urandom, $urandom, $urandom, $urandom};
    int viol = 0;
    int n = 0;
    out_ready = 1'b1; data_in = ~din; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (ABORT_STEPS) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (8) begin if (out_valid !== 1'b0) viol++; step(); end
    total++; if (viol != 0) begin bad++; $display("FAIL abort_valid got=%0d valid cycles want=0", viol); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_idle in_ready=%b want=1", in_ready); end
    data_in = din; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    total++; if (out_valid !== 1'b1 || data_out !== mix(din, 1'b1))
      begin bad++; $display("FAIL abort_next valid=%b got=%h want=%h", out_valid, data_out, mix(din, 1'b1)); end
    step();
  endtask

  task automatic test_stream();
    logic [127:0] q [$];
    logic [127:0] src;
    int acc = 0, outs = 0, cyc = 0, last = 0, ivl_bad = 0, seen_ok = 1;
    out_ready = 1'b1;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    while (outs < 8 && cyc < 300) begin
      logic took;
      took = in_valid && in_ready;
      if (took) begin
        q.push_back(data_in);
        if (acc > 0 && cyc - last != IVL) ivl_bad++;
        last = cyc;
        acc++;
      end
      step();
      cyc++;
      if (took) begin
        data_in = {$urandom, $urandom, $urandom, $urandom};
        if (acc == 8) in_valid = 1'b0;
      end
      if (out_valid === 1'b1) begin
        src = (q.size() > 0) ? q.pop_front() : 128'h0;
        total++; if (data_out !== mix(src, 1'b1))
          begin bad++; $display("FAIL stream_data[%0d] got=%h want=%h", outs, data_out, mix(src, 1'b1)); end
        total++; if (mix(data_out, 1'b0) !== src)
          begin bad++; $display("FAIL stream_roundtrip[%0d] got=%h want=%h", outs, mix(data_out, 1'b0), src); end
        outs++;
      end
    end
    in_valid = 1'b0;
    if (outs != 8) seen_ok = 0;
    total++; if (seen_ok == 0) begin bad++; $display("FAIL stream_count got=%0d want=8", outs); end
    total++; if (ivl_bad != 0) begin bad++; $display("FAIL stream_interval got=%0d off-interval accepts want=0", ivl_bad); end
    step();
  endtask

  initial begin
    test_reset();
    test_reference();
    test_second();
    test_backpressure();
    test_abort();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
